// File: rtl/freq_gate_counter_if.sv
// Result channel of the gated edge counter: one registered measurement
// offered through a valid/ready handshake, plus the sticky lost flag.
interface freq_gate_counter_if #(
   parameter int CNT_W = 32
);
   logic [CNT_W-1:0] meas_count;
   logic             meas_ovf;
   logic             meas_valid;
   logic             meas_ready;
   logic             meas_lost;

   // Producer side: the counter publishes results.
   modport master (
      output meas_count, meas_ovf, meas_valid, meas_lost,
      input  meas_ready
   );

   // Consumer side: the SPI readout stage.
   modport slave (
      input  meas_count, meas_ovf, meas_valid, meas_lost,
      output meas_ready
   );
endinterface

// File: rtl/freq_gate_counter.sv
// Gated edge counter on the PLL output clock. Waits for lock, settles,
// then counts rising edges of sig_in in back-to-back windows of
// GATE_CYCLES clocks and publishes each window's count on meas.
module freq_gate_counter #(
   parameter int GATE_CYCLES   = 100396825,
   parameter int SETTLE_CYCLES = 1024,
   parameter int CNT_W         = 32,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                 refclk,
   input  logic                 rst,
   input  logic                 pll_locked,
   input  logic                 sig_in,
   freq_gate_counter_if.master  meas,
   output logic                 gating
);

   localparam int GATE_W   = (GATE_CYCLES > 1)   ? $clog2(GATE_CYCLES)   : 1;
   localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [GATE_W-1:0]   GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      GATE      = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sig_sync;
   logic [SYNC_STAGES-1:0] lock_sync;
   logic                   sig_d;
   logic                   lk_s;
   logic                   sig_edge;

   logic [SETTLE_W-1:0]    settle_cnt;
   logic [GATE_W-1:0]      gate_cnt;
   logic [CNT_W-1:0]       edge_cnt;
   logic                   ovf;

   logic                   clr_settle;
   logic                   start_gate;
   logic                   close;
   logic [CNT_W-1:0]       edge_cnt_next;
   logic                   ovf_next;
   logic                   transfer;

   assign lk_s     = lock_sync[SYNC_STAGES-1];
   assign sig_edge = sig_sync[SYNC_STAGES-1] & ~sig_d;
   assign gating   = (state_q == GATE);
   assign transfer = meas.meas_valid & meas.meas_ready;

   // Synchronise the asynchronous inputs and delay sig_in once for edge detect.
   // NOTE: every clocked block uses <= so all flops see pre-edge values;
   // a blocking = here would collapse the synchroniser chain into one flop.
   always_ff @(posedge refclk) begin
      if (rst) begin
         sig_sync  <= '0;
         lock_sync <= '0;
         sig_d     <= 1'b0;
      end else begin
         sig_sync  <= {sig_sync[SYNC_STAGES-2:0], sig_in};
         lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
         sig_d     <= sig_sync[SYNC_STAGES-1];
      end
   end

   // State register.
   always_ff @(posedge refclk) begin
      if (rst) state_q <= WAIT_LOCK;
      else     state_q <= state_d;
   end

   // Next state and the strobes that steer the counters; lock loss wins over a close.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      clr_settle = 1'b0;
      start_gate = 1'b0;
      close      = 1'b0;
      case (state_q)
         WAIT_LOCK: begin
            if (lk_s) begin
               state_d    = SETTLE;
               clr_settle = 1'b1;
            end
         end
         SETTLE: begin
            if (!lk_s) begin
               state_d = WAIT_LOCK;
            end else if (settle_cnt == SETTLE_LAST) begin
               state_d    = GATE;
               start_gate = 1'b1;
            end
         end
         GATE: begin
            if (!lk_s)                     state_d = WAIT_LOCK;
            else if (gate_cnt == GATE_LAST) close  = 1'b1;
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   // Saturating edge count including this cycle's edge, used both mid-window and at close.
   always_comb begin
      edge_cnt_next = edge_cnt;
      ovf_next      = ovf;
      if (sig_edge) begin
         if (edge_cnt == CNT_MAX) ovf_next      = 1'b1;
         else                     edge_cnt_next = edge_cnt + 1'b1;
      end
   end

   // Settle, gate and edge counters; a close restarts the window with no dead cycle.
   // NOTE: these are plain counters, not a memory, so they take the reset
   // like any other state and the window always starts from a known zero.
   always_ff @(posedge refclk) begin
      if (rst) begin
         settle_cnt <= '0;
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         ovf        <= 1'b0;
      end else begin
         if (clr_settle)               settle_cnt <= '0;
         else if (state_q == SETTLE)   settle_cnt <= settle_cnt + 1'b1;

         if (start_gate || close) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
         end else if (state_q == GATE) begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_cnt_next;
            ovf      <= ovf_next;
         end
      end
   end

   // Publish results: a close loads a new result, an unread overwrite sets lost.
   always_ff @(posedge refclk) begin
      if (rst) begin
         meas.meas_count <= '0;
         meas.meas_ovf   <= 1'b0;
         meas.meas_valid <= 1'b0;
         meas.meas_lost  <= 1'b0;
      end else if (close) begin
         meas.meas_count <= edge_cnt_next;
         meas.meas_ovf   <= ovf_next;
         meas.meas_valid <= 1'b1;
         if (meas.meas_valid && !meas.meas_ready) meas.meas_lost <= 1'b1;
      end else if (transfer) begin
         meas.meas_valid <= 1'b0;
         meas.meas_lost  <= 1'b0;
      end
   end

endmodule
